// File: rtl/trace_pkg.sv
// Shared constants and entry-width helper for the commit trace buffer.
// Optional feature macro: TRACE_TIMESTAMP_EN (adds a cycle stamp to each stored entry).
package trace_pkg;

  localparam logic [31:0] ECALL_INSTR    = 32'h0000_0073;
  localparam logic [31:0] JAL_SELF_INSTR = 32'h0000_006f;

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_HALTED = 1'b1;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Entry layout, MSB first: {pc, instr[, stamp]}.
  function automatic int unsigned entry_width(input int unsigned xlen,
                                              input int unsigned cycle_w);
    return xlen + 32 + (TS_EN ? cycle_w : 0);
  endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// DEPTH x WIDTH trace storage: synchronous write port and registered read port.
// A read and a write to the same address in one cycle return the old contents.
module trace_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit monitor: records retired (pc, instr) pairs, detects program end, pop-style readout.
// Optional feature macro: TRACE_TIMESTAMP_EN (per-entry cycle stamp returned on rd_cycle).
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CYCLE_W      = 32,
  parameter int unsigned STOP_ON_FULL = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     commit_valid,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [31:0]              commit_instr,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_pc,
  output logic [31:0]              rd_instr,
  output logic [CYCLE_W-1:0]       rd_cycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     halted,
  output logic [CYCLE_W-1:0]       cycle_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = entry_width(XLEN, CYCLE_W);

  logic               state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               rd_valid_q, rd_valid_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;

  logic push_req, pop, is_full, push, lose, ring_adv, halt_hit;
  logic [EW-1:0] wdata, rdata;

  assign is_full  = (count_q == CW'(DEPTH));
  assign push_req = (state_q == ST_RUN) && commit_valid;
  assign pop      = rd_en && (count_q != '0);
  // A simultaneous pop frees the slot, so only an unpaired push into a full buffer loses data.
  assign lose     = push_req && is_full && !pop;
  assign push     = push_req && !(lose && (STOP_ON_FULL != 0));
  assign ring_adv = lose && (STOP_ON_FULL == 0);
  assign halt_hit = push_req &&
                    ((commit_instr == ECALL_INSTR) || (commit_instr == JAL_SELF_INSTR));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    cycle_d    = cycle_q;
    if (clear) begin
      state_d    = ST_RUN;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      cycle_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop || ring_adv) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop && !is_full) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (lose) overflow_d = 1'b1;
      if (halt_hit) state_d = ST_HALTED;
      rd_valid_d = pop;
      if ((state_q == ST_RUN) && (cycle_q != '1)) cycle_d = cycle_q + CYCLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      cycle_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      cycle_q    <= cycle_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  assign wdata    = {commit_pc, commit_instr, cycle_q};
  assign rd_pc    = rdata[EW-1 -: XLEN];
  assign rd_instr = rdata[CYCLE_W +: 32];
  assign rd_cycle = rdata[CYCLE_W-1:0];
`else
  assign wdata    = {commit_pc, commit_instr};
  assign rd_pc    = rdata[EW-1 -: XLEN];
  assign rd_instr = rdata[31:0];
  assign rd_cycle = '0;
`endif

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push && !clear),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .re    (pop && !clear),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign rd_valid    = rd_valid_q;
  assign count       = count_q;
  assign full        = is_full;
  assign empty       = (count_q == '0);
  assign overflow    = overflow_q;
  assign halted      = (state_q == ST_HALTED);
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench: ring-mode and stop-on-full instances share stimulus; each is checked against
// a sequence model (entries numbered by push order, oldest/newest indices).
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;
  localparam int LOGN  = 4096;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] stamp;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] commit_instr = '0;
  logic        rd_en = 1'b0;

  logic        r_rd_valid, s_rd_valid;
  logic [31:0] r_rd_pc, s_rd_pc, r_rd_instr, s_rd_instr, r_rd_cycle, s_rd_cycle;
  logic [4:0]  r_count, s_count;
  logic        r_full, s_full, r_empty, s_empty, r_overflow, s_overflow, r_halted, s_halted;
  logic [31:0] r_cycle_count, s_cycle_count;

  always #5 clk = ~clk;

  commit_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .CYCLE_W(32), .STOP_ON_FULL(0)) dut_ring (
    .clk (clk), .reset (reset), .clear (clear), .commit_valid (commit_valid),
    .commit_pc (commit_pc), .commit_instr (commit_instr), .rd_en (rd_en),
    .rd_valid (r_rd_valid), .rd_pc (r_rd_pc), .rd_instr (r_rd_instr), .rd_cycle (r_rd_cycle),
    .count (r_count), .full (r_full), .empty (r_empty), .overflow (r_overflow),
    .halted (r_halted), .cycle_count (r_cycle_count)
  );

  commit_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .CYCLE_W(32), .STOP_ON_FULL(1)) dut_stop (
    .clk (clk), .reset (reset), .clear (clear), .commit_valid (commit_valid),
    .commit_pc (commit_pc), .commit_instr (commit_instr), .rd_en (rd_en),
    .rd_valid (s_rd_valid), .rd_pc (s_rd_pc), .rd_instr (s_rd_instr), .rd_cycle (s_rd_cycle),
    .count (s_count), .full (s_full), .empty (s_empty), .overflow (s_overflow),
    .halted (s_halted), .cycle_count (s_cycle_count)
  );

  ent_t        log_q [2][LOGN];
  int          head [2];
  int          tail [2];
  bit          ovf [2];
  bit          hlt [2];
  bit          exp_rv [2];
  logic [31:0] cyc [2];
  ent_t        exp_rd [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      head[m] = 0; tail[m] = 0; ovf[m] = 0; hlt[m] = 0; exp_rv[m] = 0;
      cyc[m] = '0; exp_rd[m] = '0;
    end
  endtask

  task automatic model_step(input int m);
    int n;
    bit pop_ok, was_run;
    ent_t e;
    if (clear) begin
      head[m] = tail[m]; ovf[m] = 0; hlt[m] = 0; cyc[m] = '0; exp_rv[m] = 0;
    end else begin
      n       = tail[m] - head[m];
      was_run = !hlt[m];
      pop_ok  = rd_en && (n > 0);
      exp_rv[m] = pop_ok;
      if (pop_ok) begin
        exp_rd[m] = log_q[m][head[m] % LOGN];
        head[m]++;
      end
      if (was_run && commit_valid) begin
        e = '{pc: commit_pc, instr: commit_instr, stamp: cyc[m]};
        if (n == DEPTH && !pop_ok) begin
          ovf[m] = 1;
          if (m == 0) begin
            head[m]++;
            log_q[m][tail[m] % LOGN] = e;
            tail[m]++;
          end
        end else begin
          log_q[m][tail[m] % LOGN] = e;
          tail[m]++;
        end
        if (commit_instr == 32'h0000_0073 || commit_instr == 32'h0000_006f) hlt[m] = 1;
      end
      if (was_run && cyc[m] != 32'hffff_ffff) cyc[m] = cyc[m] + 1;
    end
  endtask

  task automatic check_mode(input int m);
    logic rv, fl, em, ov, ha;
    logic [4:0]  cnt;
    logic [31:0] pc, ins, rc, cc, exp_stamp;
    string pfx;
    int n;
    if (m == 0) begin
      rv = r_rd_valid; fl = r_full; em = r_empty; ov = r_overflow; ha = r_halted;
      cnt = r_count; pc = r_rd_pc; ins = r_rd_instr; rc = r_rd_cycle; cc = r_cycle_count;
      pfx = "ring";
    end else begin
      rv = s_rd_valid; fl = s_full; em = s_empty; ov = s_overflow; ha = s_halted;
      cnt = s_count; pc = s_rd_pc; ins = s_rd_instr; rc = s_rd_cycle; cc = s_cycle_count;
      pfx = "stop";
    end
    n = tail[m] - head[m];
    check_eq({pfx, ".rd_valid"}, rv, exp_rv[m]);
    check_eq({pfx, ".count"}, cnt, n);
    check_eq({pfx, ".full"}, fl, n == DEPTH);
    check_eq({pfx, ".empty"}, em, n == 0);
    check_eq({pfx, ".overflow"}, ov, ovf[m]);
    check_eq({pfx, ".halted"}, ha, hlt[m]);
    check_eq({pfx, ".cycle_count"}, cc, cyc[m]);
    if (exp_rv[m]) begin
`ifdef TRACE_TIMESTAMP_EN
      exp_stamp = exp_rd[m].stamp;
`else
      exp_stamp = '0;
`endif
      check_eq({pfx, ".rd_pc"}, pc, exp_rd[m].pc);
      check_eq({pfx, ".rd_instr"}, ins, exp_rd[m].instr);
      check_eq({pfx, ".rd_cycle"}, rc, exp_stamp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_mode(0);
    check_mode(1);
  endtask

  task automatic drive(input bit cv, input logic [31:0] pc, input logic [31:0] instr,
                       input bit re, input bit clr);
    commit_valid = cv; commit_pc = pc; commit_instr = instr; rd_en = re; clear = clr;
    tick();
  endtask

  task automatic do_reset();
    commit_valid = 0; rd_en = 0; clear = 0;
    reset = 0;
    #3;
    model_reset();
    check_mode(0);
    check_mode(1);
    check_eq("reset.rd_pc", r_rd_pc, 0);
    check_eq("reset.rd_instr", s_rd_instr, 0);
    check_eq("reset.rd_cycle", r_rd_cycle, 0);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    #2;
    do_reset();

    // In-order capture and readout, then pop on empty.
    for (int i = 0; i < 5; i++) drive(1, 32'(4 * i), 32'h13, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 0);

    // 20 commits into 16 entries: overwrite vs drop.
    do_reset();
    for (int i = 0; i < 20; i++) drive(1, 32'(4 * i), 32'h13, 0, 0);
    for (int i = 0; i < 17; i++) drive(0, 0, 0, 1, 0);

    // Halt on ecall, later commits ignored, count and cycle_count frozen, then clear.
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) drive(1, 32'(4 * i), 32'h13, 0, 0);
    drive(1, 32'h24, 32'h73, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 32'(32'h28 + 4 * i), 32'h13, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 0);
    drive(1, 32'h100, 32'h13, 1, 1);
    drive(1, 32'h40, 32'h6f, 0, 0);
    drive(0, 0, 0, 0, 1);

    // Full buffer with simultaneous commit and pop.
    for (int i = 0; i < 16; i++) drive(1, 32'(32'h200 + 4 * i), 32'h13, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 32'(32'h300 + 4 * i), 32'h13, 1, 0);
    for (int i = 0; i < 17; i++) drive(0, 0, 0, 1, 0);

    // Commits on cycles 3 and 7 after reset release.
    do_reset();
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    drive(1, 32'h500, 32'h13, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    drive(1, 32'h504, 32'h13, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);

    // Randomized traffic with occasional halts, clears and one mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] instr;
      if (i == 700) do_reset();
      instr = $urandom;
      if ($urandom_range(0, 49) == 0) instr = ($urandom_range(0, 1) != 0) ? 32'h73 : 32'h6f;
      else if ($urandom_range(0, 3) == 0) instr = 32'h13;
      drive($urandom_range(0, 99) < 60, $urandom & 32'hffff_fffc, instr,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
